axi4_lite_gpu_cmd_frontend: RTL and testbench
=============================================

// Module: axi4_lite_gpu_cmd_frontend
// PURPOSE
// AXI4-Lite slave register front end for the rectangle-fill engine. Decodes CPU register writes into the
// engine's one-cycle left/right/colour load pulses and start pulse. Captures engine busy/done/err into
// readable sticky status and raises an interrupt. Sits between the PS AXI interconnect and the rect engine.
// PARAMETERS
// ADDR_WIDTH   5   byte address bits decoded (register map 0x00-0x10; higher bits ignored)
// COLOR_WIDTH  8   colour field width; must be <= 24
// PORTS
// clk  in  1  clock
// rst_n  in  1  reset, synchronous, active-low
// s_axi_awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  write address channel
// s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel
// s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel
// s_axi_araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  read address channel
// s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel
// eng_start  out  1  one-cycle start pulse to the rect engine
// eng_busy/eng_done/eng_err  in  1 each  engine status; done/err are single-cycle pulses
// left_valid,left_x,left_y  out  1,12,12  corner-A load pulse and coordinates
// right_valid,right_x,right_y  out  1,12,12  corner-B load pulse and coordinates
// color_valid,color  out  1,COLOR_WIDTH  colour load pulse and value
// irq  out  1  level interrupt: |(sticky & enable)
// BEHAVIOUR
// Register map (word-aligned, addr[1:0] ignored):
//  0x00 CTRL   W: bit0 START (self-clearing), bit1 IRQ_EN_DONE, bit2 IRQ_EN_ERR. R: {29'b0, en_err, en_done, eng_busy}
//  0x04 LEFT   W: x=[11:0], y=[27:16]; pulses left_valid.  R: last written value
//  0x08 RIGHT  same layout; pulses right_valid.             R: last written value
//  0x0C COLOR  W: [COLOR_WIDTH-1:0]; pulses color_valid.    R: last written value
//  0x10 STATUS R: {30'b0, err_sticky, done_sticky}. W: write-1-to-clear per bit
//  Any other address: write is dropped, read returns 0; both respond SLVERR (2'b10).
// Reset: awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0, all pulses 0, x/y/colour outputs 0,
//  enables=0, stickies=0, irq=0.
// Write path: AW and W accepted independently into one-deep holding regs (awready/wready high while the
//  respective holding reg is empty and bvalid=0). Commit the cycle both are held; bvalid asserts the next cycle
//  and holds until bready. Only one write is outstanding; no new AW/W is accepted while bvalid=1.
// WSTRB: a byte lane with strobe 0 keeps its old register content; the load pulse still fires if any strobe is set.
//  If wstrb=0, no pulse fires and bresp=OKAY.
// Load pulses: exactly one cycle, asserted in the cycle after commit. x/y/colour outputs are registered and
//  stable from that cycle until the next write to the same register.
// START: bit0=1 while eng_busy=0 -> eng_start pulses 1 cycle after commit.
//  START while eng_busy=1 -> no pulse, bresp=SLVERR, enables still updated.
//  Coordinate range checking belongs to the engine; this block passes values unchecked.
// Read path: arready=1 when rvalid=0. rdata/rresp are registered and valid one cycle after the AR handshake;
//  they hold until rready. Reads and writes proceed concurrently.
// Sticky status: set on an eng_done/eng_err pulse. A same-cycle set and W1C clear -> set wins.
// irq is registered: it follows the stickies and enables with one cycle of latency.
// Reset mid-transaction: all holding regs are discarded and no pulse is emitted. The master must re-issue.
// STRUCTURE
// Package gpu_pkg:
//  - register offset localparams (REG_CTRL, REG_LEFT, REG_RIGHT, REG_COLOR, REG_STATUS)
//  - RESP_OKAY/RESP_SLVERR constants
//  - typedef coord_t (logic [11:0])
// Natural sub-module axi4_lite_slave_if: AXI channel handshakes and holding regs.
//  It exposes wr_en/wr_addr/wr_data/wr_strb/wr_err and rd_en/rd_addr/rd_data/rd_err to the register decode.
// TESTING
// 1. Write 0x04=0x0064_0032 -> left_valid pulses once, left_x=50, left_y=100; read 0x04 returns 0x00640032; bresp=OKAY.
// 2. AW presented 3 cycles before W -> one commit, one bvalid. With bready held low 5 cycles, bvalid stays high and awready=0.
// 3. Write CTRL=0x3 with eng_busy=0 -> eng_start pulse, en_done=1; engine pulses eng_done -> STATUS=0x1, irq=1 next cycle.
//    Write STATUS=0x1 -> STATUS=0x0, irq=0.
// 4. Write CTRL=0x1 while eng_busy=1 -> no eng_start, bresp=SLVERR; read CTRL bit0=1.
// 5. Write 0x14 -> SLVERR, no pulses. Read 0x18 -> rdata=0, rresp=SLVERR.
//    Write 0x0C with wstrb=0 -> no color_valid, bresp=OKAY.
// 6. Same-cycle eng_err pulse and W1C of bit1 -> err_sticky=1.
//    rst_n low while AW is held -> after reset, bvalid=0 and no pulse.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared definitions for the rect-fill command front end: register map, AXI response codes,
// coordinate type and a byte-strobe merge helper.
package gpu_pkg;
    localparam logic [31:0] REG_CTRL   = 32'h00;
    localparam logic [31:0] REG_LEFT   = 32'h04;
    localparam logic [31:0] REG_RIGHT  = 32'h08;
    localparam logic [31:0] REG_COLOR  = 32'h0C;
    localparam logic [31:0] REG_STATUS = 32'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [11:0] coord_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return res;
    endfunction
endpackage

// File: rtl/axi4_lite_slave_if.sv
// AXI4-Lite channel handshakes: one-deep AW/W holding regs, single outstanding write,
// registered read data. Presents simple wr_*/rd_* strobes to the register decode.
module axi4_lite_slave_if
    import gpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic [3:0]            wr_strb,
    input  logic                  wr_err,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [31:0]           rd_data,
    input  logic                  rd_err
);
    // live keeps every ready low while rst_n is asserted and for the first edge after it
    logic                  live;
    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [31:0]           w_data_q;
    logic [3:0]            w_strb_q;

    assign s_axi_awready = live && !aw_held && !s_axi_bvalid;
    assign s_axi_wready  = live && !w_held  && !s_axi_bvalid;
    assign s_axi_arready = live && !s_axi_rvalid;

    assign wr_en   = aw_held && w_held;
    assign wr_addr = aw_addr_q;
    assign wr_data = w_data_q;
    assign wr_strb = w_strb_q;
    assign rd_en   = s_axi_arvalid && s_axi_arready;
    assign rd_addr = s_axi_araddr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            live         <= 1'b0;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
        end else begin
            live <= 1'b1;
            if (s_axi_awvalid && s_axi_awready) begin
                aw_held   <= 1'b1;
                aw_addr_q <= s_axi_awaddr;
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_held   <= 1'b1;
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end
            // commit frees both holding regs in the same edge that raises bvalid
            if (wr_en) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
            if (rd_en) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_data;
                s_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/axi4_lite_gpu_cmd_frontend.sv
// Register decode for the rect-fill engine: corner/colour load pulses, start pulse,
// sticky done/err status with W1C and a registered interrupt.
module axi4_lite_gpu_cmd_frontend
    import gpu_pkg::*;
#(
    parameter int ADDR_WIDTH  = 5,
    parameter int COLOR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_WIDTH-1:0]  s_axi_awaddr,
    input  logic                   s_axi_awvalid,
    output logic                   s_axi_awready,
    input  logic [31:0]            s_axi_wdata,
    input  logic [3:0]             s_axi_wstrb,
    input  logic                   s_axi_wvalid,
    output logic                   s_axi_wready,
    output logic [1:0]             s_axi_bresp,
    output logic                   s_axi_bvalid,
    input  logic                   s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]  s_axi_araddr,
    input  logic                   s_axi_arvalid,
    output logic                   s_axi_arready,
    output logic [31:0]            s_axi_rdata,
    output logic [1:0]             s_axi_rresp,
    output logic                   s_axi_rvalid,
    input  logic                   s_axi_rready,
    output logic                   eng_start,
    input  logic                   eng_busy,
    input  logic                   eng_done,
    input  logic                   eng_err,
    output logic                   left_valid,
    output coord_t                 left_x,
    output coord_t                 left_y,
    output logic                   right_valid,
    output coord_t                 right_x,
    output coord_t                 right_y,
    output logic                   color_valid,
    output logic [COLOR_WIDTH-1:0] color,
    output logic                   irq
);
    logic                  wr_en, wr_err, rd_en, rd_err;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic [31:0]           wr_data, rd_data;
    logic [3:0]            wr_strb;

    axi4_lite_slave_if #(.ADDR_WIDTH(ADDR_WIDTH)) u_if (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .wr_err(wr_err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_err(rd_err)
    );

    logic [31:0] left_q, right_q, color_q;
    logic        en_done, en_err, done_st, err_st;

    // word-aligned decode: byte-lane bits of the address are masked off
    logic [31:0] wa, ra;
    assign wa = 32'(wr_addr & ~ADDR_WIDTH'(3));
    assign ra = 32'(rd_addr & ~ADDR_WIDTH'(3));

    logic w_ctrl, w_left, w_right, w_color, w_status, w_any, w_start;
    logic [1:0] clr;
    assign w_ctrl   = (wa == REG_CTRL);
    assign w_left   = (wa == REG_LEFT);
    assign w_right  = (wa == REG_RIGHT);
    assign w_color  = (wa == REG_COLOR);
    assign w_status = (wa == REG_STATUS);
    assign w_any    = |wr_strb;
    assign w_start  = w_ctrl && wr_strb[0] && wr_data[0];
    assign wr_err   = !(w_ctrl || w_left || w_right || w_color || w_status) || (w_start && eng_busy);
    assign clr      = (wr_en && w_status && wr_strb[0]) ? wr_data[1:0] : 2'b00;

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        if (rd_en) begin
            case (ra)
                REG_CTRL:   rd_data = {29'b0, en_err, en_done, eng_busy};
                REG_LEFT:   rd_data = left_q;
                REG_RIGHT:  rd_data = right_q;
                REG_COLOR:  rd_data = color_q;
                REG_STATUS: rd_data = {30'b0, err_st, done_st};
                default:    rd_err  = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            left_q      <= '0;
            right_q     <= '0;
            color_q     <= '0;
            en_done     <= 1'b0;
            en_err      <= 1'b0;
            done_st     <= 1'b0;
            err_st      <= 1'b0;
            irq         <= 1'b0;
            left_valid  <= 1'b0;
            right_valid <= 1'b0;
            color_valid <= 1'b0;
            eng_start   <= 1'b0;
        end else begin
            left_valid  <= wr_en && w_left  && w_any;
            right_valid <= wr_en && w_right && w_any;
            color_valid <= wr_en && w_color && w_any;
            eng_start   <= wr_en && w_start && !eng_busy;
            if (wr_en && w_left)  left_q  <= apply_strb(left_q,  wr_data, wr_strb);
            if (wr_en && w_right) right_q <= apply_strb(right_q, wr_data, wr_strb);
            if (wr_en && w_color) color_q <= apply_strb(color_q, wr_data, wr_strb);
            if (wr_en && w_ctrl && wr_strb[0]) {en_err, en_done} <= wr_data[2:1];
            // an engine pulse in the same cycle as a W1C keeps the bit set
            done_st <= eng_done | (done_st & ~clr[0]);
            err_st  <= eng_err  | (err_st  & ~clr[1]);
            irq     <= (done_st & en_done) | (err_st & en_err);
        end
    end

    assign left_x  = left_q[11:0];
    assign left_y  = left_q[27:16];
    assign right_x = right_q[11:0];
    assign right_y = right_q[27:16];
    assign color   = color_q[COLOR_WIDTH-1:0];
endmodule

// File: tb/tb_axi4_lite_gpu_cmd_frontend.sv
// Directed bench for the rect-fill command front end with hand-computed expectations.
module tb_axi4_lite_gpu_cmd_frontend;
    localparam int AW = 5;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 0;
    logic awready, wready, bvalid, arready, rvalid;
    logic [31:0] wdata = '0, rdata;
    logic [3:0]  wstrb = '0;
    logic [1:0]  bresp, rresp;
    logic eng_busy = 0, eng_done = 0, eng_err = 0;
    logic eng_start, left_valid, right_valid, color_valid, irq;
    logic [11:0] left_x, left_y, right_x, right_y;
    logic [CW-1:0] color;

    axi4_lite_gpu_cmd_frontend #(.ADDR_WIDTH(AW), .COLOR_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .eng_start(eng_start), .eng_busy(eng_busy), .eng_done(eng_done), .eng_err(eng_err),
        .left_valid(left_valid), .left_x(left_x), .left_y(left_y),
        .right_valid(right_valid), .right_x(right_x), .right_y(right_y),
        .color_valid(color_valid), .color(color), .irq(irq)
    );

    int n_tests = 0, n_fail = 0;
    int left_cnt = 0, right_cnt = 0, color_cnt = 0, start_cnt = 0;

    always @(posedge clk) begin
        if (left_valid)  left_cnt  <= left_cnt + 1;
        if (right_valid) right_cnt <= right_cnt + 1;
        if (color_valid) color_cnt <= color_cnt + 1;
        if (eng_start)   start_cnt <= start_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        logic aw_hs, w_hs, got;
        resp = 2'bxx;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            step();
            if (aw_hs) awvalid = 0;
            if (w_hs)  wvalid = 0;
        end
        check("wr_handshake_pending", {31'b0, awvalid | wvalid}, 0);
        awvalid = 0; wvalid = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bvalid) begin resp = bresp; got = 1; end
            step();
        end
        check("bvalid_seen", {31'b0, got}, 1);
        step();
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic hs, got;
        d = 'x; resp = 2'bxx;
        araddr = a; arvalid = 1;
        for (int i = 0; i < 20 && arvalid; i++) begin
            hs = arready;
            step();
            if (hs) arvalid = 0;
        end
        arvalid = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (rvalid) begin d = rdata; resp = rresp; got = 1; rready = 1; end
            step();
            rready = 0;
        end
        check("rvalid_seen", {31'b0, got}, 1);
    endtask

    logic [1:0]  resp;
    logic [31:0] rd;
    int l0, r0, c0, s0;

    initial begin
        // reset state
        step(); step();
        check("rst_awready", {31'b0, awready}, 0);
        check("rst_wready", {31'b0, wready}, 0);
        check("rst_arready", {31'b0, arready}, 0);
        check("rst_bvalid", {31'b0, bvalid}, 0);
        check("rst_rvalid", {31'b0, rvalid}, 0);
        check("rst_irq", {31'b0, irq}, 0);
        check("rst_left_x", {20'b0, left_x}, 0);
        check("rst_color", {24'b0, color}, 0);
        rst_n = 1;
        step();

        // 1: LEFT write and readback
        l0 = left_cnt;
        axi_write(5'h04, 32'h0064_0032, 4'hF, resp);
        check("t1_bresp", {30'b0, resp}, 2'b00);
        check("t1_left_pulses", left_cnt - l0, 1);
        check("t1_left_x", {20'b0, left_x}, 50);
        check("t1_left_y", {20'b0, left_y}, 100);
        axi_read(5'h04, rd, resp);
        check("t1_rdata", rd, 32'h0064_0032);
        check("t1_rresp", {30'b0, resp}, 2'b00);

        // 2: AW three cycles ahead of W, bready held low
        r0 = right_cnt;
        bready = 0;
        awaddr = 5'h08; awvalid = 1;
        step();
        awvalid = 0;
        step(); step();
        wdata = 32'h0003_0007; wstrb = 4'hF; wvalid = 1;
        check("t2_wready", {31'b0, wready}, 1);
        step();
        wvalid = 0;
        step();
        check("t2_bvalid_up", {31'b0, bvalid}, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_bvalid_hold", {31'b0, bvalid}, 1);
            check("t2_awready_low", {31'b0, awready}, 0);
        end
        bready = 1;
        step();
        check("t2_bvalid_drop", {31'b0, bvalid}, 0);
        step(); step();
        check("t2_right_pulses", right_cnt - r0, 1);
        check("t2_right_x", {20'b0, right_x}, 7);
        check("t2_right_y", {20'b0, right_y}, 3);

        // 3: start, done sticky, irq, W1C
        s0 = start_cnt;
        axi_write(5'h00, 32'h3, 4'hF, resp);
        check("t3_bresp", {30'b0, resp}, 2'b00);
        check("t3_start_pulses", start_cnt - s0, 1);
        eng_done = 1;
        step();
        eng_done = 0;
        check("t3_irq_latency", {31'b0, irq}, 0);
        step();
        check("t3_irq_set", {31'b0, irq}, 1);
        axi_read(5'h10, rd, resp);
        check("t3_status", rd, 32'h1);
        axi_write(5'h10, 32'h1, 4'hF, resp);
        axi_read(5'h10, rd, resp);
        check("t3_status_clr", rd, 32'h0);
        check("t3_irq_clr", {31'b0, irq}, 0);

        // 4: start while busy
        eng_busy = 1;
        s0 = start_cnt;
        axi_write(5'h00, 32'h1, 4'hF, resp);
        check("t4_bresp", {30'b0, resp}, 2'b10);
        check("t4_no_start", start_cnt - s0, 0);
        axi_read(5'h00, rd, resp);
        check("t4_ctrl", rd, 32'h1);
        eng_busy = 0;

        // 5: unmapped addresses, strobe handling
        l0 = left_cnt; r0 = right_cnt; c0 = color_cnt; s0 = start_cnt;
        axi_write(5'h14, 32'hFFFF_FFFF, 4'hF, resp);
        check("t5_wr_slverr", {30'b0, resp}, 2'b10);
        check("t5_no_pulses", (left_cnt - l0) + (right_cnt - r0) + (color_cnt - c0) + (start_cnt - s0), 0);
        axi_read(5'h18, rd, resp);
        check("t5_rd_zero", rd, 32'h0);
        check("t5_rd_slverr", {30'b0, resp}, 2'b10);
        axi_write(5'h0C, 32'h0000_00FF, 4'h0, resp);
        check("t5_strb0_bresp", {30'b0, resp}, 2'b00);
        check("t5_strb0_no_pulse", color_cnt - c0, 0);
        axi_write(5'h0C, 32'hFFFF_FFAB, 4'h1, resp);
        check("t5_partial_pulse", color_cnt - c0, 1);
        check("t5_color", {24'b0, color}, 32'hAB);
        axi_read(5'h0C, rd, resp);
        check("t5_color_rd", rd, 32'h0000_00AB);

        // 6: eng_err in the commit cycle of a W1C to bit1
        awaddr = 5'h10; wdata = 32'h2; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        step();
        awvalid = 0; wvalid = 0; eng_err = 1;
        step();
        eng_err = 0;
        check("t6_bvalid", {31'b0, bvalid}, 1);
        step();
        axi_read(5'h10, rd, resp);
        check("t6_err_set_wins", rd, 32'h2);
        axi_write(5'h10, 32'h2, 4'hF, resp);
        axi_read(5'h10, rd, resp);
        check("t6_err_cleared", rd, 32'h0);

        // 6: reset while AW is held discards it
        l0 = left_cnt;
        awaddr = 5'h04; awvalid = 1;
        step();
        awvalid = 0;
        rst_n = 0;
        step(); step();
        rst_n = 1;
        step();
        check("t6_rst_bvalid", {31'b0, bvalid}, 0);
        wdata = 32'h0001_0001; wstrb = 4'hF; wvalid = 1;
        step();
        wvalid = 0;
        step(); step();
        check("t6_rst_no_commit", {31'b0, bvalid}, 0);
        check("t6_rst_no_pulse", left_cnt - l0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
